// File: rtl/adder_stager_pkg.sv
// Shared types and sizing helpers for the byte-serial operand stager
// that feeds the external 32-bit full adder.
package adder_stager_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

   // Bytes per transaction: a, then b, then one carry-in byte.
   function automatic int calc_nb(input int data_w);
      return 2 * (data_w / 8) + 1;
   endfunction

   function automatic int calc_idx_w(input int data_w);
      return $clog2(calc_nb(data_w));
   endfunction

endpackage

// File: rtl/stager_byte_deser.sv
// Byte index counter that writes each accepted byte straight into its slice
// of the a/b/cin operand registers and flags completion of a transaction.
module stager_byte_deser
   import adder_stager_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NB     = calc_nb(DATA_W),
   parameter int IDX_W  = calc_idx_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              accept,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              op_cin,
   output logic              done,
   output logic              cin_bad
);

   localparam int NA = DATA_W / 8;

   logic [IDX_W-1:0] idx;
   logic             last;

   assign last    = accept && (idx == IDX_W'(NB - 1));
   assign cin_bad = last && (|in_data[7:1]);

   // done is registered so the FSM leaves COLLECT one edge after the last byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         op_cin <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            idx <= last ? '0 : idx + IDX_W'(1);
            for (int i = 0; i < NA; i++) begin
               if (idx == IDX_W'(i))      op_a[8*i +: 8] <= in_data;
               if (idx == IDX_W'(NA + i)) op_b[8*i +: 8] <= in_data;
            end
            if (last) op_cin <= in_data[0];
         end
      end
   end

endmodule

// File: rtl/adder_operand_stager.sv
// Sequential wrapper around a combinational adder: collects operands from a
// byte stream, drives them to the adder, and returns {cout,sum} on valid/ready.
module adder_operand_stager
   import adder_stager_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              op_cin,
   input  logic [DATA_W-1:0] add_sum,
   input  logic              add_cout,
   output logic [DATA_W:0]   out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  txn_count,
   output logic              cin_err,
   output logic [1:0]        state_dbg
);

   generate
      if (DATA_W % 8 != 0) begin : g_bad_width
         $error("adder_operand_stager: DATA_W must be a multiple of 8");
      end
   endgenerate

   // Handshakes: a byte moves when in_valid && in_ready at a rising edge;
   // a result moves when out_valid && out_ready. Either side may stall freely.
   state_e state;
   logic   done;
   logic   cin_bad;
   logic   accept;

   assign in_ready  = (state == ST_COLLECT) && !done;
   assign accept    = in_valid && in_ready;
   assign state_dbg = state;

   stager_byte_deser #(
      .DATA_W (DATA_W)
   ) u_deser (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_data (in_data),
      .accept  (accept),
      .op_a    (op_a),
      .op_b    (op_b),
      .op_cin  (op_cin),
      .done    (done),
      .cin_bad (cin_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_COLLECT;
         out_data  <= '0;
         out_valid <= 1'b0;
         txn_count <= '0;
         cin_err   <= 1'b0;
      end else begin
         if (cin_bad) cin_err <= 1'b1;
         case (state)
            ST_COLLECT: begin
               if (done) state <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               out_data  <= {add_cout, add_sum};
               out_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  txn_count <= txn_count + CNT_W'(1);
                  state     <= ST_COLLECT;
               end
            end
            default: state <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_operand_stager.sv
// Scoreboard bench for adder_operand_stager with a loopback adder; expected
// results come from plain a+b+cin arithmetic on the issued operands.
module tb_adder_operand_stager;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_cin;
   logic [DATA_W-1:0] add_sum;
   logic              add_cout;
   logic [DATA_W:0]   out_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  txn_count;
   logic              cin_err;
   logic [1:0]        state_dbg;

   adder_operand_stager #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_cin    (op_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .txn_count (txn_count),
      .cin_err   (cin_err),
      .state_dbg (state_dbg)
   );

   // Loopback adder standing in for FullAdder32.
   assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, op_cin};

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [DATA_W+1:0] exp_q[$];   // {cin_err, cout, sum}
   int  n_cmp = 0;
   int  n_bad = 0;
   int  exp_cnt = 0;
   bit  sticky = 1'b0;
   bit  rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [DATA_W+1:0] e;
      if (!rst_n) begin
         exp_cnt = 0;
      end else if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got 0x%0h with nothing outstanding at %0t", out_data, $time);
         end else begin
            e = exp_q.pop_front();
            check("result", 64'(out_data), 64'(e[DATA_W:0]));
            check("cin_err", 64'(cin_err), 64'(e[DATA_W+1]));
            check("txn_count", 64'(txn_count), 64'(exp_cnt % (1 << CNT_W)));
            exp_cnt++;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send_byte(input logic [7:0] d, input bit gaps);
      bit ok;
      int n;
      if (gaps) begin
         while ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b1;
      in_data  = d;
      n  = 0;
      ok = 1'b0;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         n++;
      end while (!ok && n < 300);
      in_valid = 1'b0;
      if (!ok) check("byte_accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic send_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] cb, input bit gaps);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b} + {32'd0, cb[0]};
      if (cb[7:1] != 7'd0) sticky = 1'b1;
      exp_q.push_back({sticky, s});
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gaps);
      for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], gaps);
      send_byte(cb, gaps);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      check("wait_out_valid", 64'(out_valid), 64'(1));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      sticky = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2;
      check("rst_op_a", 64'(op_a), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_txn_count", 64'(txn_count), 64'(0));
      apply_reset();
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_cin_err", 64'(cin_err), 64'(0));
      @(posedge clk);
      #1;

      // 1: simple sum, latency and single-cycle valid
      send_txn(32'h0000_0001, 32'h0000_0002, 8'h00, 1'b0);
      @(negedge clk);
      check("lat_edge_n", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("lat_edge_n1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("lat_edge_n2", 64'(out_valid), 64'(1));
      check("sum_1_2", 64'(out_data), 64'h0_0000_0003);
      @(negedge clk);
      check("valid_one_cycle", 64'(out_valid), 64'(0));
      check("txn_count_1", 64'(txn_count), 64'(1));
      @(posedge clk);
      #1;

      // 2: carry out, backpressure with ignored input bytes
      out_ready = 1'b0;
      send_txn(32'hFFFF_FFFF, 32'h0000_0000, 8'h01, 1'b0);
      wait_valid();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = 8'h55;
         @(negedge clk);
         check("hold_out_data", 64'(out_data), 64'h1_0000_0000);
         check("hold_out_valid", 64'(out_valid), 64'(1));
         check("hold_in_ready", 64'(in_ready), 64'(0));
         check("hold_op_a", 64'(op_a), 64'hFFFF_FFFF);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      @(posedge clk);
      #1;

      // 3: random gaps, exact operands
      send_txn(32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1'b1);
      @(negedge clk);
      check("gap_op_a", 64'(op_a), 64'h1234_5678);
      check("gap_op_b", 64'(op_b), 64'h9ABC_DEF0);
      check("gap_op_cin", 64'(op_cin), 64'(0));
      drain();
      check("gap_sum", 64'(out_data), 64'h0_ACF1_3568);
      @(posedge clk);
      #1;

      // 4: malformed cin byte, sticky error
      send_txn(32'h0000_000A, 32'h0000_0005, 8'h03, 1'b0);
      @(negedge clk);
      check("bad_cin_op_cin", 64'(op_cin), 64'(1));
      check("bad_cin_err", 64'(cin_err), 64'(1));
      drain();
      check("bad_cin_sum", 64'(out_data), 64'h0_0000_0010);
      @(posedge clk);
      #1;
      send_txn(32'h0000_0001, 32'h0000_0001, 8'h00, 1'b0);
      drain();
      check("cin_err_sticky", 64'(cin_err), 64'(1));
      apply_reset();
      @(negedge clk);
      check("cin_err_cleared", 64'(cin_err), 64'(0));
      @(posedge clk);
      #1;

      // 5: reset in the middle of a transaction
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
      send_byte(8'hEE, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_op_a", 64'(op_a), 64'(0));
      check("async_op_b", 64'(op_b), 64'(0));
      check("async_out_data", 64'(out_data), 64'(0));
      check("async_out_valid", 64'(out_valid), 64'(0));
      check("async_txn_count", 64'(txn_count), 64'(0));
      apply_reset();
      send_txn(32'h0000_1000, 32'h0000_0234, 8'h01, 1'b0);
      drain();
      check("post_reset_sum", 64'(out_data), 64'h0_0000_1235);
      check("post_reset_count", 64'(txn_count), 64'(1));
      @(posedge clk);
      #1;

      // 6: random traffic; txn_count wraps through 2^CNT_W along the way
      rand_ready = 1'b1;
      for (int t = 0; t < 1000; t++) begin
         logic [7:0] cb;
         cb = ($urandom_range(0, 9) == 0) ? 8'($urandom) : {7'd0, 1'($urandom)};
         send_txn($urandom, $urandom, cb, 1'($urandom_range(0, 1)));
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();
      check("final_count", 64'(txn_count), 64'(1001 % (1 << CNT_W)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
